// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: FSM state
// encoding, the per-instruction PC increment and the default reset vector.
package fetch_pc_unit_pkg;

  // Fetch FSM state encoding (2 bits, legacy-compatible constants).
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_VALID = 2'd2;
  localparam fetch_state_t ST_DRAIN = 2'd3;

  // Bytes per instruction word; the sequential PC step.
  localparam int INSTR_BYTES = 4;

  // PC value loaded on reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_pc_register.sv
// Program-counter register: one D flip-flop per bit, synchronous
// active-high reset to RESET_VECTOR, and a load enable that otherwise holds.
module pc_register
  import fetch_pc_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] d,
  output logic [ADDR_WIDTH-1:0] q
);

  // Bank of D flip-flops: reset wins, then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage. Owns the PC, issues one word fetch at a time over
// a req/ack handshake, and presents each instruction with its PC to decode.
// Decode stall holds the presented instruction; execute redirects either
// restart the fetch immediately or, when a request is still in flight, wait
// for its ack (DRAIN) before fetching from the redirect target.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  imemAck,
  input  logic [DATA_WIDTH-1:0] imemData,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  output logic [DATA_WIDTH-1:0] instrOut,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  instrValid
);

  // Force an address onto a word boundary; the low two bits of a redirect
  // target carry no meaning for word fetches.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    word_align = {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  // Sequential PC step; wraps modulo 2^ADDR_WIDTH without any flag.
  function automatic logic [ADDR_WIDTH-1:0] pc_step(input logic [ADDR_WIDTH-1:0] a);
    pc_step = a + ADDR_WIDTH'(INSTR_BYTES);
  endfunction

  fetch_state_t          state;
  fetch_state_t          state_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pendingTarget;
  logic [ADDR_WIDTH-1:0] pend_d;
  logic                  req_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] instr_d;
  logic [ADDR_WIDTH-1:0] pcout_d;
  logic                  valid_d;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [ADDR_WIDTH-1:0] drain_tgt;

  assign tgt = word_align(branchTarget);

  // A redirect arriving in the same cycle as the drain ack is the newest one.
  assign drain_tgt = branchTaken ? tgt : pendingTarget;

  pc_register #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  // Next-state and next-output decode for the fetch FSM; default is hold.
  always_comb begin
    state_d = state;
    pc_load = 1'b0;
    pc_d    = pc;
    pend_d  = pendingTarget;
    req_d   = imemReq;
    addr_d  = imemAddr;
    instr_d = instrOut;
    pcout_d = pcOut;
    valid_d = instrValid;

    case (state)
      ST_IDLE: begin
        // One quiet cycle after reset, then start fetching at the PC.
        state_d = ST_REQ;
        req_d   = 1'b1;
        addr_d  = pc;
      end

      ST_REQ: begin
        if (imemAck && branchTaken) begin
          // Returned word is on the wrong path: drop it and refetch at target.
          pc_load = 1'b1;
          pc_d    = tgt;
          addr_d  = tgt;
        end else if (imemAck) begin
          instr_d = imemData;
          pcout_d = pc;
          valid_d = 1'b1;
          pc_load = 1'b1;
          pc_d    = pc_step(pc);
          req_d   = 1'b0;
          state_d = ST_VALID;
        end else if (branchTaken) begin
          // Request already issued on the old address must complete first.
          pend_d  = tgt;
          state_d = ST_DRAIN;
        end
      end

      ST_VALID: begin
        if (branchTaken) begin
          // Redirect beats stall: the presented instruction is squashed.
          valid_d = 1'b0;
          pc_load = 1'b1;
          pc_d    = tgt;
          req_d   = 1'b1;
          addr_d  = tgt;
          state_d = ST_REQ;
        end else if (!stall) begin
          // Decode takes the instruction on this edge; fetch the next one.
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (imemAck) begin
          // Stale word is discarded; instrValid stays low.
          pc_load = 1'b1;
          pc_d    = drain_tgt;
          addr_d  = drain_tgt;
          state_d = ST_REQ;
        end else if (branchTaken) begin
          pend_d = tgt;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      imemReq       <= 1'b0;
      imemAddr      <= RESET_VECTOR;
      instrOut      <= '0;
      pcOut         <= '0;
      instrValid    <= 1'b0;
      pendingTarget <= '0;
    end else begin
      state         <= state_d;
      imemReq       <= req_d;
      imemAddr      <= addr_d;
      instrOut      <= instr_d;
      pcOut         <= pcout_d;
      instrValid    <= valid_d;
      pendingTarget <= pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall, redirects in
// VALID/REQ/DRAIN, reset during DRAIN, and PC wrap from a high reset vector.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemAck;
  logic [31:0] imemData;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        instrValid;

  logic        reset2;
  logic        imemAck2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic [31:0] instrOut2;
  logic [31:0] pcOut2;
  logic        instrValid2;

  int n_cmp;
  int n_bad;

  fetch_pc_unit #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .instrOut     (instrOut),
    .pcOut        (pcOut),
    .instrValid   (instrValid)
  );

  fetch_pc_unit #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk          (clk),
    .reset        (reset2),
    .stall        (1'b0),
    .branchTaken  (1'b0),
    .branchTarget (32'h0),
    .imemAck      (imemAck2),
    .imemData     (32'h1234_5678),
    .imemReq      (imemReq2),
    .imemAddr     (imemAddr2),
    .instrOut     (instrOut2),
    .pcOut        (pcOut2),
    .instrValid   (instrValid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a recognisable word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    mem = 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    reset2       = 1'b1;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
    imemAck      = 1'b0;
    imemData     = 32'h0;
    imemAck2     = 1'b1;
    tick();
    tick();

    // Reset state
    check_val("rst_req",   {31'h0, imemReq},    32'h0);
    check_val("rst_addr",  imemAddr,            32'h0);
    check_val("rst_valid", {31'h0, instrValid}, 32'h0);
    check_val("rst_instr", instrOut,            32'h0);
    check_val("rst_pc",    pcOut,               32'h0);

    // Sequential fetch with zero-wait memory: 0x0, 0x4, 0x8
    reset = 1'b0;
    tick();
    check_val("f0_req",  {31'h0, imemReq}, 32'h1);
    check_val("f0_addr", imemAddr,         32'h0);
    imemAck = 1'b1; imemData = mem(32'h0);
    tick();
    imemAck = 1'b0;
    check_val("f0_valid", {31'h0, instrValid}, 32'h1);
    check_val("f0_instr", instrOut,            mem(32'h0));
    check_val("f0_pc",    pcOut,               32'h0);
    check_val("f0_reqlo", {31'h0, imemReq},    32'h0);
    tick();
    check_val("f1_addr",  imemAddr,            32'h4);
    check_val("f1_nv",    {31'h0, instrValid}, 32'h0);
    imemAck = 1'b1; imemData = mem(32'h4);
    tick();
    imemAck = 1'b0;
    check_val("f1_instr", instrOut, mem(32'h4));
    check_val("f1_pc",    pcOut,    32'h4);
    tick();
    check_val("f2_addr", imemAddr, 32'h8);
    imemAck = 1'b1; imemData = mem(32'h8);
    tick();
    imemAck = 1'b0;
    check_val("f2_pc", pcOut, 32'h8);

    // Stall held three cycles while an instruction is presented
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("st_valid", {31'h0, instrValid}, 32'h1);
      check_val("st_instr", instrOut,            mem(32'h8));
      check_val("st_pc",    pcOut,               32'h8);
      check_val("st_req",   {31'h0, imemReq},    32'h0);
    end
    stall = 1'b0;
    tick();
    check_val("st_next_addr", imemAddr,         32'hC);
    check_val("st_next_req",  {31'h0, imemReq}, 32'h1);

    // Redirect while VALID; low target bits dropped, old pc+4 never shown
    imemAck = 1'b1; imemData = mem(32'hC);
    tick();
    imemAck = 1'b0;
    check_val("bv_pc0", pcOut, 32'hC);
    branchTaken = 1'b1; branchTarget = 32'h103;
    tick();
    branchTaken = 1'b0;
    check_val("bv_addr",  imemAddr,            32'h100);
    check_val("bv_valid", {31'h0, instrValid}, 32'h0);
    imemAck = 1'b1; imemData = mem(32'h100);
    tick();
    imemAck = 1'b0;
    check_val("bv_pc",    pcOut,    32'h100);
    check_val("bv_instr", instrOut, mem(32'h100));
    tick();
    check_val("bv_next", imemAddr, 32'h104);

    // Redirect while REQ with ack two cycles late -> DRAIN
    branchTaken = 1'b1; branchTarget = 32'h200;
    tick();
    branchTaken = 1'b0;
    check_val("dr_addr0",  imemAddr,            32'h104);
    check_val("dr_req0",   {31'h0, imemReq},    32'h1);
    check_val("dr_valid0", {31'h0, instrValid}, 32'h0);
    tick();
    check_val("dr_addr1", imemAddr, 32'h104);
    imemAck = 1'b1; imemData = mem(32'h104);
    tick();
    imemAck = 1'b0;
    check_val("dr_valid2", {31'h0, instrValid}, 32'h0);
    check_val("dr_new",    imemAddr,            32'h200);
    imemAck = 1'b1; imemData = mem(32'h200);
    tick();
    imemAck = 1'b0;
    check_val("dr_pc", pcOut, 32'h200);
    tick();
    check_val("dr_next", imemAddr, 32'h204);

    // Reset asserted in DRAIN with a pending redirect
    branchTaken = 1'b1; branchTarget = 32'h300;
    tick();
    branchTaken = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rd_req",   {31'h0, imemReq},    32'h0);
    check_val("rd_valid", {31'h0, instrValid}, 32'h0);
    tick();
    check_val("rd_addr", imemAddr,         32'h0);
    check_val("rd_reqh", {31'h0, imemReq}, 32'h1);

    // Simultaneous stall and branch in VALID: branch wins
    imemAck = 1'b1; imemData = mem(32'h0);
    tick();
    imemAck = 1'b0;
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h41;
    tick();
    stall = 1'b0; branchTaken = 1'b0;
    check_val("sb_addr",  imemAddr,            32'h40);
    check_val("sb_valid", {31'h0, instrValid}, 32'h0);

    // Two redirects during DRAIN: the later target is fetched
    branchTaken = 1'b1; branchTarget = 32'h500;
    tick();
    branchTarget = 32'h600;
    tick();
    branchTaken = 1'b0;
    check_val("lw_hold", imemAddr, 32'h40);
    imemAck = 1'b1; imemData = mem(32'h40);
    tick();
    imemAck = 1'b0;
    check_val("lw_addr", imemAddr, 32'h600);

    // Ack and branch together in REQ: data dropped, refetch at target
    imemAck = 1'b1; imemData = mem(32'h600); branchTaken = 1'b1; branchTarget = 32'h700;
    tick();
    imemAck = 1'b0; branchTaken = 1'b0;
    check_val("ab_addr",  imemAddr,            32'h700);
    check_val("ab_valid", {31'h0, instrValid}, 32'h0);

    // High reset vector: PC wraps from 0xFFFFFFFC to 0x00000000
    reset2 = 1'b0;
    tick();
    check_val("wr_addr0", imemAddr2, 32'hFFFF_FFFC);
    tick();
    check_val("wr_pc0",   pcOut2,    32'hFFFF_FFFC);
    check_val("wr_instr", instrOut2, 32'h1234_5678);
    tick();
    check_val("wr_addr1", imemAddr2, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
